// File: rtl/io_pkg.sv
// Shared definitions for the IN/OUT peripheral handshake unit.
package io_pkg;

   // Input handshake FSM encoding.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StHeld  = 2'd2,
      StReady = 2'd3
   } in_state_e;

   // Debounce window for a board clock in the tens of MHz.
   localparam int unsigned DebounceCyclesDefault = 50000;

   // Width of the OUT write counter; wraps naturally.
   localparam int unsigned OutCountWidth = 8;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises the raw active-low confirm button, debounces it and emits
// one-cycle press/release pulses on each edge of the debounced level.
module button_debouncer
   import io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n_i,
   output logic press_o,
   output logic release_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic            sync1_q, sync2_q;
   logic            key_s;
   logic            key_db_q, key_db_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;
   logic            release_q, release_d;

   // Inverting before the synchronizer makes a reset flop read as "not pressed".
   assign key_s = sync2_q;

   // Two-flop synchronizer on the asynchronous button.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= ~key_n_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive disagreeing cycles; flip the level once the run is long enough.
   always_comb begin
      key_db_d  = key_db_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (key_s != key_db_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            key_db_d  = key_s;
            press_d   = key_s;
            release_d = ~key_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounce state and edge pulses, registered together so a pulse lines up with the level change.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_db_q  <= 1'b0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         key_db_q  <= key_db_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/io_handshake_unit.sv
// Peripheral side of the IN/OUT instructions: a button-confirmed switch read
// for IN and a display register plus write counter for OUT.
module io_handshake_unit
   import io_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned SW_WIDTH        = 16,
   parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_req,
   output logic                     in_ready,
   output logic [DATA_WIDTH-1:0]    in_data,
   input  logic [SW_WIDTH-1:0]      switches,
   input  logic                     key_n,
   input  logic                     new_out,
   input  logic [DATA_WIDTH-1:0]    out_data,
   output logic [DATA_WIDTH-1:0]    out_value,
   output logic [OutCountWidth-1:0] out_count
);

   logic                     press;
   logic                     release_evt;
   in_state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0]    in_data_q, in_data_d;
   logic                     in_ready_q;
   logic [DATA_WIDTH-1:0]    out_value_q;
   logic [OutCountWidth-1:0] out_count_q;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk      (clk),
      .reset    (reset),
      .key_n_i  (key_n),
      .press_o  (press),
      .release_o(release_evt)
   );

   // Input handshake next state; a dropped request always wins over a button event.
   always_comb begin
      state_d   = state_q;
      in_data_d = in_data_q;
      unique case (state_q)
         StIdle: begin
            if (in_req) state_d = StArmed;
         end
         StArmed: begin
            if (!in_req) begin
               state_d = StIdle;
            end else if (press) begin
               in_data_d = DATA_WIDTH'(switches);
               state_d   = StHeld;
            end
         end
         StHeld: begin
            if (!in_req) begin
               state_d = StIdle;
            end else if (release_evt) begin
               state_d = StReady;
            end
         end
         StReady: begin
            if (!in_req) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Input handshake state, latched word and registered ready flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         in_data_q  <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_data_q  <= in_data_d;
         in_ready_q <= (state_d == StReady);
      end
   end

   // OUT path: capture the value and count every cycle the strobe is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_value_q <= '0;
         out_count_q <= '0;
      end else if (new_out) begin
         out_value_q <= out_data;
         out_count_q <= out_count_q + 1'b1;
      end
   end

   assign in_ready  = in_ready_q;
   assign in_data   = in_data_q;
   assign out_value = out_value_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Self-checking bench for io_handshake_unit with a behavioural reference model.
module tb_io_handshake_unit;

   localparam int unsigned DW = 32;
   localparam int unsigned SW = 16;
   localparam int unsigned DB = 4;

   localparam int PhIdle = 0;
   localparam int PhWait = 1;
   localparam int PhHeld = 2;
   localparam int PhDone = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_req;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [SW-1:0] switches;
   logic          key_n;
   logic          new_out;
   logic [DW-1:0] out_data;
   logic [DW-1:0] out_value;
   logic [7:0]    out_count;

   int checks = 0;
   int errors = 0;

   io_handshake_unit #(
      .DATA_WIDTH     (DW),
      .SW_WIDTH       (SW),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_req   (in_req),
      .in_ready (in_ready),
      .in_data  (in_data),
      .switches (switches),
      .key_n    (key_n),
      .new_out  (new_out),
      .out_data (out_data),
      .out_value(out_value),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   // Reference model. The debounced level flips when the last DB synchronised
   // samples (raw pressed level delayed by two edges) all disagree with it.
   logic [DB:0]   m_raw       = '0;
   logic          m_db        = 1'b0;
   logic          m_press     = 1'b0;
   logic          m_release   = 1'b0;
   logic          m_all_diff  = 1'b0;
   int            m_phase     = PhIdle;
   logic [DW-1:0] m_in_data   = '0;
   logic [DW-1:0] m_out_value = '0;
   logic [7:0]    m_out_count = '0;
   logic          m_in_ready  = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_raw       = '0;
         m_db        = 1'b0;
         m_press     = 1'b0;
         m_release   = 1'b0;
         m_phase     = PhIdle;
         m_in_data   = '0;
         m_out_value = '0;
         m_out_count = '0;
         m_in_ready  = 1'b0;
      end else begin
         case (m_phase)
            PhIdle: if (in_req) m_phase = PhWait;
            PhWait: begin
               if (!in_req) m_phase = PhIdle;
               else if (m_press) begin
                  m_in_data = DW'(switches);
                  m_phase   = PhHeld;
               end
            end
            PhHeld: begin
               if (!in_req) m_phase = PhIdle;
               else if (m_release) m_phase = PhDone;
            end
            default: if (!in_req) m_phase = PhIdle;
         endcase
         m_in_ready = (m_phase == PhDone);
         if (new_out) begin
            m_out_value = out_data;
            m_out_count = m_out_count + 8'd1;
         end
         m_all_diff = 1'b1;
         for (int i = 1; i <= DB; i++) if (m_raw[i] == m_db) m_all_diff = 1'b0;
         m_press   = m_all_diff && !m_db;
         m_release = m_all_diff && m_db;
         if (m_all_diff) m_db = !m_db;
         m_raw = {m_raw[DB-1:0], ~key_n};
      end
   end

   task automatic settle();
      in_req  = 1'b0;
      key_n   = 1'b1;
      new_out = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      new_out  = 1'b1;
      key_n    = 1'b0;
      in_req   = 1'b1;
      switches = 16'hFFFF;
      out_data = $urandom() | 32'h1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, in_data, out_value, out_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs c=%0d: in_ready=%b in_data=%h out_value=%h out_count=%0d, want all 0",
                     c, in_ready, in_data, out_value, out_count);
         end
      end
      reset   = 1'b0;
      new_out = 1'b0;
      key_n   = 1'b1;
      in_req  = 1'b0;
      @(negedge clk);
      checks++;
      if (out_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_count_after: out_count=%0d want 0", out_count);
      end
      checks++;
      if (in_ready !== 1'b0 || in_data !== '0) begin
         errors++;
         $display("FAIL reset_in_after: in_ready=%b in_data=%h want 0 0", in_ready, in_data);
      end
      settle();
   endtask

   task automatic test_basic();
      int rise = -1;
      switches = 16'hA5C3;
      in_req   = 1'b1;
      for (int c = 0; c < 40; c++) begin
         key_n = (c >= 2 && c < 12) ? 1'b0 : 1'b1;
         if (rise >= 0 && c == rise + 1) in_req = 1'b0;
         @(negedge clk);
         checks++;
         if (in_ready !== m_in_ready || in_data !== m_in_data) begin
            errors++;
            $display("FAIL basic_track c=%0d: in_ready=%b in_data=%h, model %b %h",
                     c, in_ready, in_data, m_in_ready, m_in_data);
         end
         if (rise >= 0 && c == rise + 1) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL basic_ready_fall: in_ready=%b want 0", in_ready);
            end
         end
         if (in_ready === 1'b1 && rise < 0) begin
            rise = c;
            checks++;
            if (in_data !== 32'h0000A5C3) begin
               errors++;
               $display("FAIL basic_data: in_data=%h want 0000a5c3", in_data);
            end
         end
      end
      checks++;
      if (rise < 0) begin
         errors++;
         $display("FAIL basic_timeout: in_ready never rose in 40 cycles");
      end
      settle();
   endtask

   task automatic test_bounce();
      int            rises   = 0;
      int            changes = 0;
      logic          prev_rdy;
      logic [DW-1:0] prev_data;
      in_req    = 1'b1;
      prev_rdy  = in_ready;
      prev_data = in_data;
      for (int c = 0; c < 60; c++) begin
         switches = {1'b0, 15'($urandom())};
         if (c < 20)      key_n = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
         else if (c < 34) key_n = 1'b0;
         else             key_n = 1'b1;
         @(negedge clk);
         checks++;
         if (in_ready !== m_in_ready || in_data !== m_in_data) begin
            errors++;
            $display("FAIL bounce_track c=%0d: in_ready=%b in_data=%h, model %b %h",
                     c, in_ready, in_data, m_in_ready, m_in_data);
         end
         if (in_ready === 1'b1 && prev_rdy !== 1'b1) rises++;
         if (in_data !== prev_data) changes++;
         prev_rdy  = in_ready;
         prev_data = in_data;
      end
      checks++;
      if (changes != 1) begin
         errors++;
         $display("FAIL bounce_captures: in_data changed %0d times want 1", changes);
      end
      checks++;
      if (rises != 1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bounce_ready: rises=%0d in_ready=%b want 1 1", rises, in_ready);
      end
      in_req = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bounce_ready_fall: in_ready=%b want 0", in_ready);
      end
      settle();
   endtask

   task automatic test_held_at_arm();
      logic [SW-1:0] sw1 = {1'b0, 15'($urandom())};
      logic [SW-1:0] sw2 = {1'b1, 15'($urandom())};
      switches = sw1;
      in_req   = 1'b0;
      key_n    = 1'b0;
      for (int c = 0; c < 70; c++) begin
         if (c == 12) in_req = 1'b1;
         if (c == 20) key_n = 1'b1;
         if (c == 32) begin
            switches = sw2;
            key_n    = 1'b0;
         end
         if (c == 44) key_n = 1'b1;
         @(negedge clk);
         checks++;
         if (in_ready !== m_in_ready || in_data !== m_in_data) begin
            errors++;
            $display("FAIL held_track c=%0d: in_ready=%b in_data=%h, model %b %h",
                     c, in_ready, in_data, m_in_ready, m_in_data);
         end
         if (c == 30) begin
            checks++;
            if (in_ready !== 1'b0 || in_data === DW'(sw1)) begin
               errors++;
               $display("FAIL held_no_capture: in_ready=%b in_data=%h, want 0 and not %h",
                        in_ready, in_data, sw1);
            end
         end
      end
      checks++;
      if (in_ready !== 1'b1 || in_data !== DW'(sw2)) begin
         errors++;
         $display("FAIL held_second_press: in_ready=%b in_data=%h want 1 %h", in_ready, in_data,
                  DW'(sw2));
      end
      settle();
   endtask

   task automatic test_abort_held();
      logic [SW-1:0] sw1 = SW'($urandom());
      logic [SW-1:0] sw2 = ~sw1;
      switches = sw1;
      in_req   = 1'b1;
      for (int c = 0; c < 80; c++) begin
         if (c == 12) in_req = 1'b0;
         if (c == 30) in_req = 1'b1;
         if (c == 36) switches = sw2;
         key_n = ((c >= 2 && c < 14) || (c >= 40 && c < 52)) ? 1'b0 : 1'b1;
         @(negedge clk);
         checks++;
         if (in_ready !== m_in_ready || in_data !== m_in_data) begin
            errors++;
            $display("FAIL abort_track c=%0d: in_ready=%b in_data=%h, model %b %h",
                     c, in_ready, in_data, m_in_ready, m_in_data);
         end
         if (c == 10) begin
            checks++;
            if (in_data !== DW'(sw1)) begin
               errors++;
               $display("FAIL abort_first_capture: in_data=%h want %h", in_data, DW'(sw1));
            end
         end
         if (c < 40 && in_ready !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL abort_ready_early c=%0d: in_ready=%b want 0", c, in_ready);
         end
      end
      checks++;
      if (in_ready !== 1'b1 || in_data !== DW'(sw2)) begin
         errors++;
         $display("FAIL abort_rerequest: in_ready=%b in_data=%h want 1 %h", in_ready, in_data,
                  DW'(sw2));
      end
      settle();
   endtask

   task automatic test_out_wrap();
      int            n;
      int            k          = 0;
      int            coincide_c = -1;
      logic [SW-1:0] sw         = SW'($urandom());
      n = (254 - int'(m_out_count)) & 255;
      for (int c = 0; c < n; c++) begin
         new_out  = 1'b1;
         out_data = $urandom();
         @(negedge clk);
      end
      new_out = 1'b0;
      @(negedge clk);
      checks++;
      if (out_count !== 8'd254 || out_value !== m_out_value) begin
         errors++;
         $display("FAIL out_preload: out_count=%0d out_value=%h want 254 %h", out_count, out_value,
                  m_out_value);
      end
      switches = sw;
      in_req   = 1'b1;
      for (int c = 0; c < 50; c++) begin
         key_n   = (c >= 2 && c < 12) ? 1'b0 : 1'b1;
         new_out = 1'b0;
         if ((k < 3 && c == 3 * k + 1) || (k == 3 && m_phase == PhHeld && m_release) ||
             (k == 4 && coincide_c >= 0 && c > coincide_c + 2)) begin
            k++;
            new_out  = 1'b1;
            out_data = DW'(k);
            if (k == 4) coincide_c = c;
         end
         @(negedge clk);
         checks++;
         if (out_value !== m_out_value || out_count !== m_out_count ||
             in_ready !== m_in_ready || in_data !== m_in_data) begin
            errors++;
            $display("FAIL out_track c=%0d: out=%h/%0d in=%b/%h, model %h/%0d %b/%h", c, out_value,
                     out_count, in_ready, in_data, m_out_value, m_out_count, m_in_ready, m_in_data);
         end
         if (c == coincide_c) begin
            checks++;
            if (in_ready !== 1'b1 || out_count !== 8'd2 || out_value !== 32'd4) begin
               errors++;
               $display("FAIL out_coincide: in_ready=%b out_count=%0d out_value=%0d want 1 2 4",
                        in_ready, out_count, out_value);
            end
         end
      end
      new_out = 1'b0;
      checks++;
      if (coincide_c < 0 || k != 5) begin
         errors++;
         $display("FAIL out_schedule: coincide_c=%0d pulses=%0d want >=0 and 5", coincide_c, k);
      end
      checks++;
      if (out_value !== 32'd5 || out_count !== 8'd3) begin
         errors++;
         $display("FAIL out_final: out_value=%0d out_count=%0d want 5 3", out_value, out_count);
      end
      checks++;
      if (in_ready !== 1'b1 || in_data !== DW'(sw)) begin
         errors++;
         $display("FAIL out_handshake: in_ready=%b in_data=%h want 1 %h", in_ready, in_data,
                  DW'(sw));
      end
      settle();
   endtask

   task automatic test_random_traffic();
      int ready_cycles = 0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0)  key_n = ~key_n;
         if ($urandom_range(0, 15) == 0) in_req = ~in_req;
         new_out  = ($urandom_range(0, 3) == 0);
         out_data = $urandom();
         switches = SW'($urandom());
         reset    = (c == 300 || c == 301);
         @(negedge clk);
         checks++;
         if (in_ready !== m_in_ready || in_data !== m_in_data ||
             out_value !== m_out_value || out_count !== m_out_count) begin
            errors++;
            $display("FAIL random_track c=%0d: in=%b/%h out=%h/%0d, model %b/%h %h/%0d", c,
                     in_ready, in_data, out_value, out_count, m_in_ready, m_in_data, m_out_value,
                     m_out_count);
         end
         if (in_ready === 1'b1) ready_cycles++;
      end
      reset = 1'b0;
      settle();
   endtask

   initial begin
      reset    = 1'b1;
      in_req   = 1'b0;
      key_n    = 1'b1;
      new_out  = 1'b0;
      switches = '0;
      out_data = '0;
      test_reset();
      test_basic();
      test_bounce();
      test_held_at_arm();
      test_abort_held();
      test_out_wrap();
      test_random_traffic();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
